// File: rtl/tv_recorder.sv
// Test-vector recorder: captures a packed vector on each sample strobe into an
// internal memory, then replays the stored vectors over a valid/ready stream.
module tv_recorder #(
   parameter  int WIDTH = 4,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             arm,
   input  logic             sample,
   input  logic [WIDTH-1:0] vec,
   input  logic             stop,
   output logic             capturing,
   output logic             done,
   output logic [AW:0]      count,
   output logic             overflow,
   input  logic             dump,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_last
);

   typedef enum logic [1:0] {IDLE, CAPTURE, DONE, DUMP} state_t;

   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             store;

   assign wr_ptr    = count[AW-1:0];
   assign store     = (state == CAPTURE) && sample;
   assign capturing = (state == CAPTURE);
   assign done      = (state == DONE);
   assign rd_valid  = (state == DUMP);
   assign rd_last   = rd_valid && ({1'b0, rd_ptr} == count - CNT_ONE);
   // Outside DUMP the read port is forced to zero so it is never X after reset.
   assign rd_data   = rd_valid ? mem[rd_ptr] : '0;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (arm) state_nxt = CAPTURE;
         CAPTURE: if (stop || (sample && count == CNT_FULL - CNT_ONE)) state_nxt = DONE;
         DONE: begin
            if (arm)                        state_nxt = CAPTURE;
            else if (dump && count != '0)   state_nxt = DUMP;
         end
         DUMP:    if (rd_ready && rd_last) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         count    <= '0;
         overflow <= 1'b0;
         rd_ptr   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (arm) begin
                  count    <= '0;
                  overflow <= 1'b0;
               end
            end
            CAPTURE: begin
               if (sample) count <= count + CNT_ONE;
            end
            DONE: begin
               if (sample && count == CNT_FULL) overflow <= 1'b1;
               // A fresh arm clears overflow even if a lost sample lands on the same edge.
               if (arm) begin
                  count    <= '0;
                  overflow <= 1'b0;
               end else if (dump && count != '0) begin
                  rd_ptr <= '0;
               end
            end
            DUMP: begin
               if (rd_ready) rd_ptr <= rd_ptr + PTR_ONE;
            end
            default: ;
         endcase
      end
   end

   // Storage is not reset; writes are simply suppressed on a reset edge.
   always_ff @(posedge clk) begin
      if (reset && store) mem[wr_ptr] <= vec;
   end

endmodule
